// File: rtl/ifu_imem_arb.sv
// Arbiter sharing one instruction-memory fetch port between the IFU and the CGRA config loader.
// Tracks outstanding requests in order and routes each response back to its issuing source.
module ifu_imem_arb #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 2,
  parameter int STARVE_LIM = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_req_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic          ifu_rsp_err,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          cgra_req_valid,
  output logic          cgra_req_ready,
  input  logic [AW-1:0] cgra_req_addr,
  output logic          cgra_rsp_valid,
  input  logic          cgra_rsp_ready,
  output logic          cgra_rsp_err,
  output logic [DW-1:0] cgra_rsp_rdata,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_rsp_valid,
  output logic          mem_rsp_ready,
  input  logic          mem_rsp_err,
  input  logic [DW-1:0] mem_rsp_rdata,
  input  logic          arb_halt_req,
  output logic          arb_halt_ack,
  output logic          arb_err
);

  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(OUTS_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [PW-1:0] PTR_LAST   = PW'(OUTS_DEPTH - 1);

  // Every channel uses valid/ready: a transfer happens in a cycle where both are high;
  // a requester holds valid and its payload stable until that cycle.
  logic [OUTS_DEPTH-1:0] src_mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  lock_r;
  logic                  lock_src_r;
  logic [SW-1:0]         starve_cnt;
  logic                  halt_ack_r;
  logic                  arb_err_r;

  logic fifo_empty;
  logic can_issue;
  logic starved;
  logic sel_cgra;
  logic sel_valid;
  logic head_src;
  logic push;
  logic pop;
  logic cgra_hs;

  assign fifo_empty = (cnt == '0);
  // Fullness is judged on the registered count, so a pop never frees a slot in its own cycle.
  assign can_issue  = (cnt < CNT_MAX) & (~arb_halt_req | lock_r);
  assign starved    = (starve_cnt == STARVE_MAX);
  assign sel_cgra   = lock_r ? lock_src_r
                             : (cgra_req_valid & (~ifu_req_valid | starved));
  assign sel_valid  = sel_cgra ? cgra_req_valid : ifu_req_valid;

  assign mem_req_valid  = can_issue & sel_valid;
  assign mem_req_addr   = sel_cgra ? cgra_req_addr : ifu_req_addr;
  assign ifu_req_ready  = ~sel_cgra & can_issue & mem_req_ready;
  assign cgra_req_ready = sel_cgra & can_issue & mem_req_ready;

  assign push    = mem_req_valid & mem_req_ready;
  assign cgra_hs = push & sel_cgra;

  assign head_src       = src_mem[rd_ptr];
  assign ifu_rsp_valid  = mem_rsp_valid & ~fifo_empty & ~head_src;
  assign cgra_rsp_valid = mem_rsp_valid & ~fifo_empty & head_src;
  assign ifu_rsp_err    = mem_rsp_err;
  assign ifu_rsp_rdata  = mem_rsp_rdata;
  assign cgra_rsp_err   = mem_rsp_err;
  assign cgra_rsp_rdata = mem_rsp_rdata;
  // With nothing outstanding a stray response is drained rather than left to block the bus.
  assign mem_rsp_ready  = fifo_empty ? 1'b1 : (head_src ? cgra_rsp_ready : ifu_rsp_ready);
  assign pop            = mem_rsp_valid & mem_rsp_ready & ~fifo_empty;

  assign arb_halt_ack = halt_ack_r;
  assign arb_err      = arb_err_r;

  always_ff @(posedge clk) begin
    if (push) src_mem[wr_ptr] <= sel_cgra;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // The lock keeps the granted source stable until a presented request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_r     <= 1'b0;
      lock_src_r <= 1'b0;
    end else if (push) begin
      lock_r     <= 1'b0;
    end else if (mem_req_valid) begin
      lock_r     <= 1'b1;
      lock_src_r <= sel_cgra;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (cgra_hs || !cgra_req_valid) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_ack_r <= 1'b0;
      arb_err_r  <= 1'b0;
    end else begin
      halt_ack_r <= arb_halt_req & fifo_empty & ~lock_r;
      if (mem_rsp_valid && fifo_empty) arb_err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifu_imem_arb.sv
// Bench for ifu_imem_arb: randomized sources and memory checked each cycle against a
// queue-based reference model, plus directed starvation, back-pressure, halt and error steps.
module tb_ifu_imem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0] ifu_req_addr, ifu_rsp_rdata;
  logic        cgra_req_valid, cgra_req_ready, cgra_rsp_valid, cgra_rsp_ready, cgra_rsp_err;
  logic [31:0] cgra_req_addr, cgra_rsp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic [31:0] mem_req_addr, mem_rsp_rdata;
  logic        arb_halt_req, arb_halt_ack, arb_err;

  always #5 clk = ~clk;

  ifu_imem_arb dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_err(ifu_rsp_err),
    .ifu_rsp_rdata(ifu_rsp_rdata),
    .cgra_req_valid(cgra_req_valid), .cgra_req_ready(cgra_req_ready),
    .cgra_req_addr(cgra_req_addr), .cgra_rsp_valid(cgra_rsp_valid),
    .cgra_rsp_ready(cgra_rsp_ready), .cgra_rsp_err(cgra_rsp_err),
    .cgra_rsp_rdata(cgra_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_err(mem_rsp_err),
    .mem_rsp_rdata(mem_rsp_rdata),
    .arb_halt_req(arb_halt_req), .arb_halt_ack(arb_halt_ack), .arb_err(arb_err)
  );

  localparam int DEPTH = 2;
  localparam int LIM   = 8;

  int n_chk  = 0;
  int n_pass = 0;

  // stimulus knobs (percent probabilities)
  int ifu_pct, cgra_pct, mrdy_pct, rsp_pct, srdy_pct;
  bit halt, spur;

  // reference model: source order of outstanding requests, pending memory addresses,
  // per-source expected {err, data}
  bit          src_q[$];
  logic [31:0] mem_q[$];
  logic [32:0] ifu_exp_q[$];
  logic [32:0] cgra_exp_q[$];
  int          m_starve;
  bit          m_lock, m_lock_src, m_hack, m_err;

  bit ifu_hs_d, cgra_hs_d, mrsp_hs_d, rsp_spur;
  int cgra_wait, last_wait, n_ifu_rsp, n_cgra_rsp;
  logic obs_mvalid, obs_hack, obs_err;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return a[3] & a[4];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_req_valid = 0; cgra_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    mem_rsp_err = 0; mem_rsp_rdata = '0; ifu_rsp_ready = 0; cgra_rsp_ready = 0;
    arb_halt_req = 0; spur = 0; halt = 0;
    ifu_req_addr = 32'h8000_0000; cgra_req_addr = 32'h4000_0000;
    src_q.delete(); mem_q.delete(); ifu_exp_q.delete(); cgra_exp_q.delete();
    m_starve = 0; m_lock = 0; m_lock_src = 0; m_hack = 0; m_err = 0;
    ifu_hs_d = 0; cgra_hs_d = 0; mrsp_hs_d = 0; rsp_spur = 0; cgra_wait = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_arb_err", arb_err, 0);
    rst = 1'b0;
  endtask

  task automatic step();
    int cnt;
    bit can, sel_c, e_mvalid, e_iready, e_cready, e_irv, e_crv, e_mrr, head;
    bit req_hs, pop, n_hack;
    logic [31:0] e_addr;
    @(negedge clk);
    if (ifu_hs_d) begin ifu_req_valid = 0; ifu_req_addr = ifu_req_addr + 4; end
    if (cgra_hs_d) begin cgra_req_valid = 0; cgra_req_addr = cgra_req_addr + 4; end
    if (mrsp_hs_d) begin mem_rsp_valid = 0; rsp_spur = 0; end
    if (!ifu_req_valid) ifu_req_valid = ($urandom_range(99) < ifu_pct);
    if (!cgra_req_valid) cgra_req_valid = ($urandom_range(99) < cgra_pct);
    mem_req_ready = ($urandom_range(99) < mrdy_pct);
    if (!mem_rsp_valid) begin
      if (mem_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
        mem_rsp_valid = 1; mem_rsp_rdata = data_of(mem_q[0]); mem_rsp_err = err_of(mem_q[0]);
      end else if (spur && mem_q.size() == 0) begin
        mem_rsp_valid = 1; mem_rsp_rdata = 32'hDEAD_BEEF; mem_rsp_err = 0; rsp_spur = 1;
      end
    end
    ifu_rsp_ready  = ($urandom_range(99) < srdy_pct);
    cgra_rsp_ready = ($urandom_range(99) < srdy_pct);
    arb_halt_req   = halt;
    #1;
    cnt      = src_q.size();
    head     = (cnt > 0) ? src_q[0] : 1'b0;
    can      = (cnt < DEPTH) && (!halt || m_lock);
    sel_c    = m_lock ? m_lock_src : (cgra_req_valid && (!ifu_req_valid || m_starve == LIM));
    e_mvalid = can && (sel_c ? cgra_req_valid : ifu_req_valid);
    e_addr   = sel_c ? cgra_req_addr : ifu_req_addr;
    e_iready = can && !sel_c && mem_req_ready;
    e_cready = can && sel_c && mem_req_ready;
    e_irv    = mem_rsp_valid && cnt > 0 && !head;
    e_crv    = mem_rsp_valid && cnt > 0 && head;
    e_mrr    = (cnt == 0) ? 1'b1 : (head ? cgra_rsp_ready : ifu_rsp_ready);
    chk("mem_req_valid", mem_req_valid, e_mvalid);
    if (e_mvalid) chk("mem_req_addr", mem_req_addr, e_addr);
    chk("ifu_req_ready", ifu_req_ready, e_iready);
    chk("cgra_req_ready", cgra_req_ready, e_cready);
    chk("ifu_rsp_valid", ifu_rsp_valid, e_irv);
    chk("cgra_rsp_valid", cgra_rsp_valid, e_crv);
    chk("mem_rsp_ready", mem_rsp_ready, e_mrr);
    if (e_irv) chk("ifu_rsp_data", {ifu_rsp_err, ifu_rsp_rdata}, ifu_exp_q[0]);
    if (e_crv) chk("cgra_rsp_data", {cgra_rsp_err, cgra_rsp_rdata}, cgra_exp_q[0]);
    chk("arb_halt_ack", arb_halt_ack, m_hack);
    chk("arb_err", arb_err, m_err);
    obs_mvalid = mem_req_valid; obs_hack = arb_halt_ack; obs_err = arb_err;
    if (ifu_rsp_valid && ifu_rsp_ready) n_ifu_rsp++;
    if (cgra_rsp_valid && cgra_rsp_ready) n_cgra_rsp++;
    if (cgra_req_valid) begin
      cgra_wait++;
      if (cgra_req_ready) begin last_wait = cgra_wait; cgra_wait = 0; end
    end
    @(posedge clk);
    req_hs = e_mvalid && mem_req_ready;
    pop    = mem_rsp_valid && e_mrr && cnt > 0;
    n_hack = halt && cnt == 0 && !m_lock;
    if (pop) begin
      void'(src_q.pop_front());
      void'(mem_q.pop_front());
      if (head) void'(cgra_exp_q.pop_front());
      else      void'(ifu_exp_q.pop_front());
    end
    if (req_hs) begin
      src_q.push_back(sel_c);
      mem_q.push_back(e_addr);
      if (sel_c) cgra_exp_q.push_back({err_of(e_addr), data_of(e_addr)});
      else       ifu_exp_q.push_back({err_of(e_addr), data_of(e_addr)});
    end
    if (req_hs) m_lock = 0;
    else if (e_mvalid) begin m_lock = 1; m_lock_src = sel_c; end
    if ((req_hs && sel_c) || !cgra_req_valid) m_starve = 0;
    else if (m_starve < LIM) m_starve++;
    m_hack = n_hack;
    if (mem_rsp_valid && cnt == 0) m_err = 1;
    ifu_hs_d  = req_hs && !sel_c;
    cgra_hs_d = req_hs && sel_c;
    mrsp_hs_d = mem_rsp_valid && e_mrr;
  endtask

  initial begin
    ifu_pct = 0; cgra_pct = 0; mrdy_pct = 100; rsp_pct = 100; srdy_pct = 100;
    do_reset();
    repeat (2) step();

    // IFU alone, back-to-back fetches from 0x80000000
    n_ifu_rsp = 0; n_cgra_rsp = 0;
    ifu_pct = 100;
    repeat (4) step();
    ifu_pct = 0;
    repeat (5) step();
    chk("ifu_only_rsp_count", n_ifu_rsp, 4);
    chk("ifu_only_cgra_rsp", n_cgra_rsp, 0);

    // both valid continuously: CGRA wins on its 9th waiting cycle
    ifu_pct = 100;
    repeat (2) step();
    cgra_pct = 100; cgra_wait = 0; last_wait = 0;
    repeat (12) step();
    chk("starve_wait", last_wait, LIM + 1);
    ifu_pct = 0; cgra_pct = 0;
    repeat (5) step();

    // outstanding limit with memory responses stalled
    ifu_pct = 100; rsp_pct = 0;
    repeat (4) step();
    chk("full_no_issue", obs_mvalid, 0);
    rsp_pct = 100;
    repeat (4) step();

    // halt with two outstanding
    rsp_pct = 0;
    repeat (3) step();
    halt = 1;
    repeat (2) step();
    rsp_pct = 100;
    repeat (6) step();
    chk("halt_ack_high", obs_hack, 1);
    chk("halt_no_issue", obs_mvalid, 0);
    halt = 0;
    repeat (3) step();
    chk("halt_ack_low", obs_hack, 0);
    ifu_pct = 0;
    repeat (5) step();

    // stray response with nothing outstanding
    spur = 1;
    step();
    spur = 0;
    repeat (3) step();
    chk("arb_err_sticky", obs_err, 1);
    do_reset();
    step();
    chk("arb_err_cleared", obs_err, 0);

    // randomized phases
    for (int p = 0; p < 8; p++) begin
      ifu_pct  = $urandom_range(100);
      cgra_pct = $urandom_range(100);
      mrdy_pct = $urandom_range(100, 20);
      rsp_pct  = $urandom_range(100, 10);
      srdy_pct = $urandom_range(100, 20);
      halt     = ($urandom_range(3) == 0);
      repeat (60) step();
    end
    halt = 0; ifu_pct = 0; cgra_pct = 0; mrdy_pct = 100; rsp_pct = 100; srdy_pct = 100;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
